// File: rtl/sqrt_pkg.sv
// Shared constants for the square-root datapath, its scheduler and the bench.
package sqrt_pkg;

    localparam int unsigned DATA_W          = 16;
    localparam int unsigned ROOT_W          = DATA_W / 2;
    localparam int unsigned N_REQ_DEFAULT   = 4;
    localparam int unsigned MAX_OUT_DEFAULT = 4;

    // Bits needed to index 'value' entries; never less than one.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        bits = 1;
        while ((64'd1 << bits) < 64'(value)) begin
            bits++;
        end
        return bits;
    endfunction

endpackage

// File: rtl/sqrt_tag_fifo.sv
// Synchronous tag FIFO: holds the requester tag of every operation in flight,
// in issue order, so results can be routed back strictly first-in first-out.
module sqrt_tag_fifo
    import sqrt_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 2,
    localparam int unsigned PTR_W = clog2(DEPTH),
    localparam int unsigned CNT_W = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // Pop needs an entry; push into a full FIFO only when a pop frees the slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/sqrt_rr_scheduler.sv
// Round-robin front end sharing one in-order sqrt pipe between N_REQ clients;
// results are steered back to their issuer via a FIFO of requester tags.
module sqrt_rr_scheduler
    import sqrt_pkg::*;
#(
    parameter int unsigned N_REQ   = N_REQ_DEFAULT,
    parameter int unsigned MAX_OUT = MAX_OUT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ*DATA_W-1:0] req_valor_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic                    pipe_start_o,
    output logic [DATA_W-1:0]       pipe_valor_o,
    input  logic                    pipe_done_i,
    input  logic [ROOT_W-1:0]       pipe_root_i,
    output logic [N_REQ-1:0]        rsp_valid_o,
    output logic [ROOT_W-1:0]       rsp_root_o,
    output logic                    busy_o,
    output logic                    err_o
);

    localparam int unsigned TAG_W = clog2(N_REQ);
    localparam int unsigned CNT_W = clog2(MAX_OUT + 1);

    logic [TAG_W-1:0]  rr_ptr;
    logic [TAG_W-1:0]  gnt_idx;
    logic              any_valid;
    logic              eligible;
    logic              handshake;
    logic [N_REQ-1:0]  grant;
    logic [TAG_W-1:0]  head_tag;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              rsp_hit;
    logic [DATA_W-1:0] valor_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign valor_arr[g] = req_valor_i[g*DATA_W +: DATA_W];
    end

    // Full FIFO means MAX_OUT operations in flight; a same-cycle done only helps next cycle.
    assign eligible  = !fifo_full && rst_n;
    assign handshake = any_valid && eligible;

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin
        logic [TAG_W-1:0] cand;
        cand      = '0;
        gnt_idx   = '0;
        any_valid = 1'b0;
        grant     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = TAG_W'((32'(rr_ptr) + k) % N_REQ);
            if (!any_valid && req_valid_i[cand]) begin
                any_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
        if (handshake) begin
            grant[gnt_idx] = 1'b1;
        end
    end

    assign req_ready_o = grant;
    assign rsp_hit     = pipe_done_i && !fifo_empty;
    assign busy_o      = (fifo_count != '0);

    sqrt_tag_fifo #(
        .DEPTH (MAX_OUT),
        .WIDTH (TAG_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (handshake),
        .push_data (gnt_idx),
        .pop       (pipe_done_i),
        .pop_data  (head_tag),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Issue and response stages; data registers hold between strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr       <= '0;
            pipe_start_o <= 1'b0;
            pipe_valor_o <= '0;
            rsp_valid_o  <= '0;
            rsp_root_o   <= '0;
            err_o        <= 1'b0;
        end else begin
            pipe_start_o <= handshake;
            rsp_valid_o  <= '0;
            if (handshake) begin
                pipe_valor_o <= valor_arr[gnt_idx];
                rr_ptr       <= (gnt_idx == TAG_W'(N_REQ - 1)) ? '0 : gnt_idx + TAG_W'(1);
            end
            if (rsp_hit) begin
                rsp_valid_o[head_tag] <= 1'b1;
                rsp_root_o            <= pipe_root_i;
            end
            if (pipe_done_i && fifo_empty) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sqrt_rr_scheduler.sv
// Bench for sqrt_rr_scheduler: directed scenarios plus a randomized run against
// a queue-based model, with a behavioural in-order sqrt pipe driving the results.
module tb_sqrt_rr_scheduler;
    import sqrt_pkg::*;

    localparam int unsigned N  = 4;
    localparam int unsigned MO = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [N-1:0]        req_valid = '0;
    logic [DATA_W-1:0]   ops_drv [N];
    logic [N*DATA_W-1:0] req_valor;
    logic [N-1:0]        req_ready_o;
    logic                pipe_start_o;
    logic [DATA_W-1:0]   pipe_valor_o;
    logic                pipe_done = 1'b0;
    logic [ROOT_W-1:0]   pipe_root = '0;
    logic [N-1:0]        rsp_valid_o;
    logic [ROOT_W-1:0]   rsp_root_o;
    logic                busy_o;
    logic                err_o;

    // Pipe model controls, written only by the test sequence.
    logic              pipe_auto  = 1'b0;
    logic              pipe_hold  = 1'b0;
    logic              pipe_flush = 1'b0;
    logic              pipe_rand  = 1'b0;
    int                pipe_lat   = 2;
    logic              man_done   = 1'b0;
    logic [ROOT_W-1:0] man_root   = '0;

    int                cyc = 0;
    int                last_due = 0;
    int                pq_due [$];
    logic [ROOT_W-1:0] pq_root [$];

    int errors = 0;
    int checks = 0;

    for (genvar g = 0; g < N; g++) begin : g_flat
        assign req_valor[g*DATA_W +: DATA_W] = ops_drv[g];
    end

    sqrt_rr_scheduler #(.N_REQ(N), .MAX_OUT(MO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid),
        .req_valor_i  (req_valor),
        .req_ready_o  (req_ready_o),
        .pipe_start_o (pipe_start_o),
        .pipe_valor_o (pipe_valor_o),
        .pipe_done_i  (pipe_done),
        .pipe_root_i  (pipe_root),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_root_o   (rsp_root_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [ROOT_W-1:0] isqrt(input logic [DATA_W-1:0] v);
        int r;
        r = 0;
        while ((r + 1) * (r + 1) <= int'(v)) r++;
        return ROOT_W'(r);
    endfunction

    // In-order sqrt pipe: accepts every start strobe, returns roots after a latency.
    always begin
        @(posedge clk);
        cyc++;
        #2;
        if (pipe_flush) begin
            pq_due.delete();
            pq_root.delete();
            last_due = 0;
        end
        if (pipe_auto) begin
            if (!pipe_hold && pq_due.size() > 0 && pq_due[0] <= cyc) begin
                pipe_done = 1'b1;
                pipe_root = pq_root.pop_front();
                void'(pq_due.pop_front());
            end else begin
                pipe_done = 1'b0;
                pipe_root = ROOT_W'($urandom);
            end
        end else begin
            pipe_done = man_done;
            pipe_root = man_root;
        end
        @(negedge clk);
        if (pipe_auto && pipe_start_o === 1'b1) begin
            int due;
            due = cyc + (pipe_rand ? int'($urandom_range(1, 6)) : pipe_lat);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pq_due.push_back(due);
            pq_root.push_back(isqrt(pipe_valor_o));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n      = 1'b0;
        req_valid  = '0;
        man_done   = 1'b0;
        pipe_auto  = 1'b0;
        pipe_hold  = 1'b0;
        pipe_rand  = 1'b0;
        pipe_flush = 1'b1;
        tick();
        tick();
        pipe_flush = 1'b0;
        rst_n      = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        for (int i = 0; i < N; i++) ops_drv[i] = 16'h1234;
        man_done  = 1'b1;
        man_root  = 8'h5A;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (req_ready_o !== '0) begin
            errors++; $display("FAIL reset_ready: got %b expected 0", req_ready_o);
        end
        checks++;
        if ({pipe_start_o, pipe_valor_o, rsp_valid_o, rsp_root_o, busy_o, err_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: start=%b valor=%h rsp=%b root=%h busy=%b err=%b expected all 0",
                     pipe_start_o, pipe_valor_o, rsp_valid_o, rsp_root_o, busy_o, err_o);
        end
        man_done = 1'b0;
        reset_dut();
    endtask

    task automatic test_single();
        reset_dut();
        ops_drv[2] = 16'h0051;
        repeat (5) tick();
        req_valid = 4'b0100;
        @(negedge clk);
        checks++;
        if (req_ready_o !== 4'b0100) begin
            errors++; $display("FAIL single_ready: got %b expected 0100", req_ready_o);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL single_idle_busy: got %b expected 0", busy_o);
        end
        tick();
        req_valid = '0;
        man_done  = 1'b1;
        man_root  = 8'h09;
        @(negedge clk);
        checks++;
        if (pipe_start_o !== 1'b1 || pipe_valor_o !== 16'h0051) begin
            errors++; $display("FAIL single_issue: start=%b valor=%h expected 1/0051", pipe_start_o, pipe_valor_o);
        end
        checks++;
        if (busy_o !== 1'b1) begin
            errors++; $display("FAIL single_busy: got %b expected 1", busy_o);
        end
        tick();
        man_done = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid_o !== 4'b0100 || rsp_root_o !== 8'h09) begin
            errors++; $display("FAIL single_rsp: valid=%b root=%h expected 0100/09", rsp_valid_o, rsp_root_o);
        end
        checks++;
        if (pipe_start_o !== 1'b0 || pipe_valor_o !== 16'h0051 || busy_o !== 1'b0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL single_after: start=%b valor=%h busy=%b err=%b expected 0/0051/0/0",
                     pipe_start_o, pipe_valor_o, busy_o, err_o);
        end
    endtask

    task automatic test_round_robin();
        logic [DATA_W-1:0] ops   [4];
        logic [ROOT_W-1:0] roots [4];
        logic [N-1:0]      exp_v;
        ops   = '{16'h0010, 16'h0019, 16'h0024, 16'h0031};
        roots = '{8'h04, 8'h05, 8'h06, 8'h07};
        reset_dut();
        pipe_auto = 1'b1;
        pipe_lat  = 2;
        for (int i = 0; i < N; i++) ops_drv[i] = ops[i];
        req_valid = '1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            exp_v = N'(1) << (c % 4);
            checks++;
            if (req_ready_o !== exp_v) begin
                errors++; $display("FAIL rr_grant c%0d: got %b expected %b", c, req_ready_o, exp_v);
            end
            if (c >= 1) begin
                checks++;
                if (pipe_start_o !== 1'b1 || pipe_valor_o !== ops[(c - 1) % 4]) begin
                    errors++;
                    $display("FAIL rr_issue c%0d: start=%b valor=%h expected 1/%h",
                             c, pipe_start_o, pipe_valor_o, ops[(c - 1) % 4]);
                end
            end
            if (c >= 4) begin
                exp_v = N'(1) << ((c - 4) % 4);
                checks++;
                if (rsp_valid_o !== exp_v || rsp_root_o !== roots[(c - 4) % 4]) begin
                    errors++;
                    $display("FAIL rr_rsp c%0d: valid=%b root=%h expected %b/%h",
                             c, rsp_valid_o, rsp_root_o, exp_v, roots[(c - 4) % 4]);
                end
            end
            tick();
        end
        req_valid = '0;
        repeat (6) tick();
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || err_o !== 1'b0) begin
            errors++; $display("FAIL rr_drain: busy=%b err=%b expected 0/0", busy_o, err_o);
        end
    endtask

    task automatic test_full_stall();
        logic [N-1:0] exp_v;
        reset_dut();
        pipe_auto  = 1'b1;
        pipe_lat   = 1;
        pipe_hold  = 1'b1;
        ops_drv[0] = 16'h0100;
        ops_drv[1] = 16'h0400;
        ops_drv[2] = 16'h0900;
        ops_drv[3] = 16'h1000;
        req_valid  = '1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            exp_v = (c < 4) ? N'(1) << c : '0;
            checks++;
            if (req_ready_o !== exp_v) begin
                errors++; $display("FAIL full_grant c%0d: got %b expected %b", c, req_ready_o, exp_v);
            end
            if (c >= 4) begin
                checks++;
                if (busy_o !== 1'b1) begin
                    errors++; $display("FAIL full_busy c%0d: got %b expected 1", c, busy_o);
                end
            end
            if (c == 9) begin
                checks++;
                if (rsp_valid_o !== '0 || rsp_root_o !== '0) begin
                    errors++; $display("FAIL full_hold_rsp: valid=%b root=%h expected 0/00", rsp_valid_o, rsp_root_o);
                end
                pipe_hold = 1'b0;
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (req_ready_o !== '0) begin
            errors++; $display("FAIL full_done_cycle: got %b expected 0000", req_ready_o);
        end
        tick();
        @(negedge clk);
        checks++;
        if (req_ready_o !== 4'b0001) begin
            errors++; $display("FAIL full_freed: got %b expected 0001", req_ready_o);
        end
        checks++;
        if (rsp_valid_o !== 4'b0001 || rsp_root_o !== 8'h10) begin
            errors++; $display("FAIL full_rsp: valid=%b root=%h expected 0001/10", rsp_valid_o, rsp_root_o);
        end
        tick();
        req_valid = '0;
        repeat (20) tick();
    endtask

    task automatic test_simul_done();
        logic [N-1:0]      exp_tags  [4];
        logic [ROOT_W-1:0] exp_roots [4];
        exp_tags  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_roots = '{8'h21, 8'h22, 8'h23, 8'h24};
        reset_dut();
        for (int i = 0; i < N; i++) ops_drv[i] = 16'(i * 100 + 7);
        req_valid = '1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready_o !== N'(1) << c) begin
                errors++; $display("FAIL simul_fill c%0d: got %b expected %b", c, req_ready_o, N'(1) << c);
            end
            tick();
        end
        req_valid = 4'b1000;
        man_done  = 1'b1;
        man_root  = 8'h11;
        @(negedge clk);
        checks++;
        if (req_ready_o !== 4'b1000) begin
            errors++; $display("FAIL simul_grant: got %b expected 1000", req_ready_o);
        end
        tick();
        req_valid = '1;
        man_done  = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid_o !== 4'b0001 || rsp_root_o !== 8'h11) begin
            errors++; $display("FAIL simul_rsp: valid=%b root=%h expected 0001/11", rsp_valid_o, rsp_root_o);
        end
        checks++;
        if (req_ready_o !== 4'b0001) begin
            errors++; $display("FAIL simul_count3: got %b expected 0001", req_ready_o);
        end
        tick();
        man_done = 1'b1;
        man_root = exp_roots[0];
        @(negedge clk);
        checks++;
        if (req_ready_o !== '0) begin
            errors++; $display("FAIL simul_count4: got %b expected 0000", req_ready_o);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            req_valid = '0;
            man_done  = (k < 3);
            man_root  = (k < 3) ? exp_roots[k + 1] : 8'h00;
            @(negedge clk);
            checks++;
            if (rsp_valid_o !== exp_tags[k] || rsp_root_o !== exp_roots[k]) begin
                errors++;
                $display("FAIL simul_drain%0d: valid=%b root=%h expected %b/%h",
                         k, rsp_valid_o, rsp_root_o, exp_tags[k], exp_roots[k]);
            end
        end
        tick();
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || rsp_valid_o !== '0 || err_o !== 1'b0) begin
            errors++; $display("FAIL simul_end: busy=%b rsp=%b err=%b expected 0/0/0", busy_o, rsp_valid_o, err_o);
        end
    endtask

    task automatic test_spurious();
        reset_dut();
        man_done = 1'b1;
        man_root = 8'hAA;
        tick();
        man_done = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid_o !== '0 || rsp_root_o !== '0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL spur_rsp: valid=%b root=%h busy=%b expected 0/00/0", rsp_valid_o, rsp_root_o, busy_o);
        end
        checks++;
        if (err_o !== 1'b1) begin
            errors++; $display("FAIL spur_err: got %b expected 1", err_o);
        end
        repeat (5) tick();
        @(negedge clk);
        checks++;
        if (err_o !== 1'b1) begin
            errors++; $display("FAIL spur_sticky: got %b expected 1", err_o);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (err_o !== 1'b0) begin
            errors++; $display("FAIL spur_clear: got %b expected 0", err_o);
        end
    endtask

    task automatic test_reset_midflight();
        bit seen;
        reset_dut();
        pipe_auto = 1'b1;
        pipe_lat  = 6;
        for (int i = 0; i < N; i++) ops_drv[i] = 16'(i * 17 + 3);
        req_valid = 4'b0111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (req_ready_o !== N'(1) << c) begin
                errors++; $display("FAIL mid_fill c%0d: got %b expected %b", c, req_ready_o, N'(1) << c);
            end
            tick();
        end
        req_valid = 4'b1000;
        rst_n     = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready_o !== '0 || busy_o !== 1'b1) begin
            errors++; $display("FAIL mid_rst_low: ready=%b busy=%b expected 0000/1", req_ready_o, busy_o);
        end
        tick();
        rst_n     = 1'b1;
        req_valid = '0;
        @(negedge clk);
        checks++;
        if ({pipe_start_o, pipe_valor_o, rsp_valid_o, rsp_root_o, busy_o, err_o} !== '0) begin
            errors++;
            $display("FAIL mid_cleared: start=%b valor=%h rsp=%b root=%h busy=%b err=%b expected all 0",
                     pipe_start_o, pipe_valor_o, rsp_valid_o, rsp_root_o, busy_o, err_o);
        end
        repeat (4) tick();
        @(negedge clk);
        checks++;
        if (err_o !== 1'b1 || rsp_valid_o !== '0) begin
            errors++; $display("FAIL mid_late_done: err=%b rsp=%b expected 1/0000", err_o, rsp_valid_o);
        end
        tick();
        tick();
        ops_drv[1] = 16'h00C4;
        req_valid  = 4'b1010;
        @(negedge clk);
        checks++;
        if (req_ready_o !== 4'b0010) begin
            errors++; $display("FAIL mid_ptr0: got %b expected 0010", req_ready_o);
        end
        tick();
        req_valid = '0;
        seen = 1'b0;
        for (int w = 0; w < 30; w++) begin
            @(negedge clk);
            if (rsp_valid_o !== '0) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL mid_new_rsp: no response within 30 cycles, expected 0010/0e");
        end else if (rsp_valid_o !== 4'b0010 || rsp_root_o !== 8'h0E) begin
            errors++; $display("FAIL mid_new_rsp: valid=%b root=%h expected 0010/0e", rsp_valid_o, rsp_root_o);
        end
    endtask

    task automatic test_random();
        int                ptr_m;
        int                tagq [$];
        int                g;
        int                idx;
        bit                prev_hs;
        int                prev_g;
        logic [DATA_W-1:0] prev_op;
        logic [DATA_W-1:0] exp_valor;
        bit                prev_done;
        logic [ROOT_W-1:0] prev_root;
        logic [ROOT_W-1:0] exp_root;
        logic [N-1:0]      exp_rsp;
        logic [N-1:0]      exp_ready;
        bit                exp_err;
        reset_dut();
        pipe_auto = 1'b1;
        pipe_rand = 1'b1;
        ptr_m = 0; prev_hs = 0; prev_g = 0; prev_op = '0; exp_valor = '0;
        prev_done = 0; prev_root = '0; exp_root = '0; exp_err = 0;
        for (int n = 0; n < 500; n++) begin
            req_valid = N'($urandom | $urandom);
            if ($urandom_range(0, 7) == 0) req_valid = '0;
            for (int i = 0; i < N; i++) ops_drv[i] = DATA_W'($urandom);
            @(negedge clk);
            exp_rsp = '0;
            if (prev_done) begin
                if (tagq.size() > 0) begin
                    exp_rsp  = N'(1) << tagq.pop_front();
                    exp_root = prev_root;
                end else begin
                    exp_err = 1'b1;
                end
            end
            if (prev_hs) begin
                tagq.push_back(prev_g);
                exp_valor = prev_op;
            end
            checks++;
            if (pipe_start_o !== prev_hs || pipe_valor_o !== exp_valor) begin
                errors++;
                $display("FAIL rand_issue n%0d: start=%b valor=%h expected %b/%h",
                         n, pipe_start_o, pipe_valor_o, prev_hs, exp_valor);
            end
            checks++;
            if (rsp_valid_o !== exp_rsp || rsp_root_o !== exp_root) begin
                errors++;
                $display("FAIL rand_rsp n%0d: valid=%b root=%h expected %b/%h",
                         n, rsp_valid_o, rsp_root_o, exp_rsp, exp_root);
            end
            checks++;
            if (busy_o !== (tagq.size() != 0) || err_o !== exp_err) begin
                errors++;
                $display("FAIL rand_status n%0d: busy=%b err=%b expected %b/%b",
                         n, busy_o, err_o, tagq.size() != 0, exp_err);
            end
            g = -1;
            if (tagq.size() < MO) begin
                for (int d = 0; d < N; d++) begin
                    idx = (ptr_m + d) % N;
                    if (g < 0 && ((req_valid >> idx) & N'(1)) != '0) g = idx;
                end
            end
            exp_ready = (g >= 0) ? N'(1) << g : '0;
            checks++;
            if (req_ready_o !== exp_ready) begin
                errors++; $display("FAIL rand_grant n%0d: got %b expected %b", n, req_ready_o, exp_ready);
            end
            prev_hs = (g >= 0);
            if (prev_hs) begin
                prev_g  = g;
                prev_op = ops_drv[g];
                ptr_m   = (g + 1) % N;
            end
            prev_done = pipe_done;
            prev_root = pipe_root;
            tick();
        end
        req_valid = '0;
        repeat (30) tick();
    endtask

    initial begin
        for (int i = 0; i < N; i++) ops_drv[i] = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_full_stall();
        test_simul_done();
        test_spurious();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sqrt_rr_scheduler.md
Name: sqrt_rr_scheduler

Overview:
- Shares one square-root pipeline (16-bit operand in, 8-bit root out, results in issue order) between N_REQ independent requesters.
- Round-robin arbitration of requests; each accepted operand is issued to the pipe with a requester tag.
- Each pipe result is routed back to the requester that issued it.
- Sits between the client blocks and the sqrt pipe instance. Bounds outstanding operations by MAX_OUT.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_W, 16, operand width
ROOT_W, 8, root width (DATA_W/2)
MAX_OUT, 4, max in-flight operations, power of two, ≥ pipe depth for full throughput

Ports:
clk  in  1  clock; the block's only clock
rst_n  in  1  synchronous, active-low reset
req_valid_i  in  N_REQ  per-requester request valid
req_valor_i  in  N_REQ*DATA_W  flattened operands, requester i at [i*DATA_W +: DATA_W]
req_ready_o  out  N_REQ  one-hot grant; handshake = valid & ready in the same cycle
pipe_start_o  out  1  one-cycle issue strobe to pipe
pipe_valor_o  out  DATA_W  operand to pipe, valid when pipe_start_o=1
pipe_done_i  in  1  one-cycle pulse: pipe_root_i valid
pipe_root_i  in  ROOT_W  pipe result
rsp_valid_o  out  N_REQ  one-hot response pulse
rsp_root_o  out  ROOT_W  response data, valid with rsp_valid_o
busy_o  out  1  outstanding count ≠ 0
err_o  out  1  sticky: pipe_done_i with no tag outstanding

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Outputs: req_ready_o=0, pipe_start_o=0, pipe_valor_o=0, rsp_valid_o=0, rsp_root_o=0, busy_o=0, err_o=0.
  - Internal state: RR pointer=0, tag FIFO emptied, outstanding count=0.
  - Reset mid-operation discards all in-flight tags. Results arriving after reset set err_o.
- Arbitration (combinational):
  - eligible = (count < MAX_OUT) & ~rst_n_low.
  - Grant the first requester with req_valid_i=1, searching from the RR pointer upward and wrapping modulo N_REQ.
  - At most one bit of req_ready_o is set, and only for a valid requester. req_ready_o=0 when not eligible.
  - Requesters must not make valid depend on ready.
- Pointer update: after a grant to requester i, pointer ← (i+1) mod N_REQ. With no grant, the pointer holds.
- Issue, 1-cycle latency:
  - A handshake at edge t registers the operand and tag.
  - pipe_start_o=1 during cycle t+1, with pipe_valor_o equal to the granted operand.
  - Back-to-back issue every cycle is allowed.
  - pipe_valor_o holds its last value when pipe_start_o=0.
- Tag FIFO: depth MAX_OUT, width clog2(N_REQ). Pushed at handshake; popped on pipe_done_i.
- Outstanding count:
  - +1 on handshake, −1 on pipe_done_i with count>0.
  - A simultaneous handshake and done leaves count unchanged.
  - count never exceeds MAX_OUT. Full means grants are blocked; a done in the same cycle frees a slot from the next cycle only.
- Response, 1-cycle latency:
  - pipe_done_i at edge d gives rsp_valid_o[head_tag]=1 and rsp_root_o=pipe_root_i during cycle d+1.
  - rsp_root_o holds otherwise.
  - There is no response backpressure; requesters must accept.
- Empty boundary: pipe_done_i with count=0 means no pop, no rsp_valid_o, and err_o←1 until reset.
- In-order assumption: results are matched strictly FIFO. The pipe must never reorder results.
- No state machine beyond pointer/FIFO/count. The whole block is fully pipelined.

Decomposition:
- Shared constants package sqrt_pkg: DATA_W=16, ROOT_W=8, TAG_W function clog2, and the default N_REQ/MAX_OUT. The sqrt datapath and testbench reuse it.
- One sub-module, sqrt_tag_fifo: synchronous FIFO with push/pop/full/empty/count. Simultaneous push+pop is legal when full or empty (empty: push only).
- Arbiter and pointer stay inline.

Test Plan:
1. Single request: requester 2 sends valor=0x0051 at cycle 5 → req_ready_o=0b0100 at cycle 5, pipe_start_o with 0x0051 at cycle 6. Model returns done with root=0x09 → rsp_valid_o=0b0100, rsp_root_o=0x09 one cycle later.
2. Round robin: all 4 valid continuously (operands 0x0010, 0x0019, 0x0024, 0x0031), pipe depth 3 → grants 0,1,2,3,0,… one per cycle. Responses come back 0x04, 0x05, 0x06, 0x07 tagged 0,1,2,3 in order.
3. Full stall: MAX_OUT=4, pipe holds results for 10 cycles → exactly 4 grants, then req_ready_o=0 and busy_o=1. First done frees one grant the cycle after the done.
4. Simultaneous done+handshake at count=MAX_OUT-1 → count stays 3, FIFO head/tail correct, no lost tag.
5. Spurious done: pipe_done_i with root=0xAA and nothing outstanding → rsp_valid_o stays 0, err_o=1 sticky until rst_n=0.
6. Reset mid-flight: 3 outstanding, rst_n=0 for 1 cycle → all outputs 0, busy_o=0. A late pipe_done_i then sets err_o; a new request works with pointer=0.
